// File: rtl/spi_cmd_decoder.sv
// spi_cmd_decoder: byte-level command decoder behind an SPI slave.
// Frames are cmd + data bytes; keeps an auto-incrementing register file.
//
// Ports:
//   clk, rst_n         clock, synchronous active-low reset
//   cs_n               synchronised chip select (low = frame active)
//   rx_byte, rx_valid  received byte and its one-cycle strobe
//   tx_byte            next byte for the slave shift register
//   regs_flat          register file, reg k at [8k+7:8k]
//   wr_strobe, wr_addr one-cycle write pulse and its address
//   frame_done         pulse when a non-empty frame ends
//   cmd_err            pulse on an invalid command byte
module spi_cmd_decoder #(
    parameter int          NREGS    = 16,
    parameter logic [7:0]  ID_VALUE = 8'hA5,
    parameter logic [7:0]  ERR_BYTE = 8'hEE
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      cs_n,
    input  logic [7:0]                rx_byte,
    input  logic                      rx_valid,
    output logic [7:0]                tx_byte,
    output logic [8*NREGS-1:0]        regs_flat,
    output logic                      wr_strobe,
    output logic [$clog2(NREGS)-1:0]  wr_addr,
    output logic                      frame_done,
    output logic                      cmd_err
);

    localparam int AW = $clog2(NREGS);

    typedef enum logic [2:0] {
        IDLE,
        CMD,
        WRITE,
        READ,
        DISCARD
    } state_t;

    state_t        state;
    logic [AW-1:0] ptr;
    logic [7:0]    regs [NREGS];
    logic          got_byte;
    // Set once cs_n has been seen high since reset; a frame
    // that straddles reset is never decoded.
    logic          armed;

    logic [AW-1:0] ptr_nxt;
    logic [AW-1:0] cmd_addr;
    logic          cmd_ok;

    assign ptr_nxt  = ptr + AW'(1);
    assign cmd_addr = rx_byte[AW-1:0];
    assign cmd_ok   = ({1'b0, rx_byte[6:0]} < 8'(NREGS));

    // regs[0] holds ID_VALUE from reset and is never written.
    always_comb begin
        regs_flat = '0;
        for (int k = 0; k < NREGS; k++) begin
            regs_flat[8*k +: 8] = regs[k];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            ptr        <= '0;
            tx_byte    <= 8'h00;
            wr_strobe  <= 1'b0;
            wr_addr    <= '0;
            frame_done <= 1'b0;
            cmd_err    <= 1'b0;
            got_byte   <= 1'b0;
            armed      <= 1'b0;
            regs[0]    <= ID_VALUE;
            for (int k = 1; k < NREGS; k++) begin
                regs[k] <= 8'h00;
            end
        end else begin
            wr_strobe  <= 1'b0;
            frame_done <= 1'b0;
            cmd_err    <= 1'b0;
            if (cs_n) begin
                // cs_n wins over a coincident rx_valid
                armed      <= 1'b1;
                state      <= IDLE;
                tx_byte    <= 8'h00;
                got_byte   <= 1'b0;
                frame_done <= (state != IDLE) && got_byte;
            end else begin
                if (rx_valid && state != IDLE) begin
                    got_byte <= 1'b1;
                end
                unique case (state)
                    IDLE: begin
                        if (armed) begin
                            state <= CMD;
                        end
                    end
                    CMD: begin
                        if (rx_valid) begin
                            if (!cmd_ok) begin
                                state   <= DISCARD;
                                cmd_err <= 1'b1;
                                tx_byte <= ERR_BYTE;
                            end else if (rx_byte[7]) begin
                                state   <= READ;
                                ptr     <= cmd_addr;
                                tx_byte <= regs[cmd_addr];
                            end else begin
                                state <= WRITE;
                                ptr   <= cmd_addr;
                            end
                        end
                    end
                    WRITE: begin
                        if (rx_valid) begin
                            if (ptr != '0) begin
                                regs[ptr] <= rx_byte;
                            end
                            wr_strobe <= 1'b1;
                            wr_addr   <= ptr;
                            ptr       <= ptr_nxt;
                        end
                    end
                    READ: begin
                        if (rx_valid) begin
                            ptr     <= ptr_nxt;
                            tx_byte <= regs[ptr_nxt];
                        end
                    end
                    DISCARD: begin
                        tx_byte <= ERR_BYTE;
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_spi_cmd_decoder.sv
// tb_spi_cmd_decoder: directed self-checking bench for spi_cmd_decoder.
// NREGS = 16, ID_VALUE = A5, ERR_BYTE = EE.
module tb_spi_cmd_decoder;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         cs_n;
    logic [7:0]   rx_byte;
    logic         rx_valid;
    logic [7:0]   tx_byte;
    logic [127:0] regs_flat;
    logic         wr_strobe;
    logic [3:0]   wr_addr;
    logic         frame_done;
    logic         cmd_err;

    int pass = 0;
    int total = 0;
    logic [7:0] m [16];

    spi_cmd_decoder #(
        .NREGS(16),
        .ID_VALUE(8'hA5),
        .ERR_BYTE(8'hEE)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .cs_n(cs_n),
        .rx_byte(rx_byte),
        .rx_valid(rx_valid),
        .tx_byte(tx_byte),
        .regs_flat(regs_flat),
        .wr_strobe(wr_strobe),
        .wr_addr(wr_addr),
        .frame_done(frame_done),
        .cmd_err(cmd_err)
    );

    always #5 clk = ~clk;

    function automatic logic [127:0] mflat();
        logic [127:0] f;
        for (int k = 0; k < 16; k++) f[8*k +: 8] = m[k];
        return f;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cs_low();
        cs_n = 1'b0;
        tick();
    endtask

    task automatic cs_high();
        cs_n = 1'b1;
        tick();
        tick();
    endtask

    task automatic put(input logic [7:0] b);
        rx_byte  = b;
        rx_valid = 1'b1;
        tick();
        rx_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; cs_n = 1'b1; rx_valid = 1'b0; rx_byte = 8'h00;
        for (int k = 0; k < 16; k++) m[k] = 8'h00;
        m[0] = 8'hA5;
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
        total++;
        if (tx_byte !== 8'h00) $display("FAIL rst_tx got=%h exp=00", tx_byte);
        else pass++;
        total++;
        if (regs_flat !== mflat()) $display("FAIL rst_regs got=%h exp=%h", regs_flat, mflat());
        else pass++;
        total++;
        if ({wr_strobe, frame_done, cmd_err} !== 3'b000)
            $display("FAIL rst_pulses got=%b exp=000", {wr_strobe, frame_done, cmd_err});
        else pass++;
        // reset in the middle of a write frame
        cs_low();
        put(8'h01);
        rst_n = 1'b0;
        repeat (2) tick();
        total++;
        if ({tx_byte, wr_strobe, frame_done, cmd_err} !== 11'h000)
            $display("FAIL midrst_out got=%h/%b exp=00/000", tx_byte, {wr_strobe, frame_done, cmd_err});
        else pass++;
        rst_n = 1'b1;
        put(8'h77);
        total++;
        if (wr_strobe !== 1'b0) $display("FAIL midrst_nowr got=%b exp=0", wr_strobe);
        else pass++;
        cs_n = 1'b1;
        tick();
        total++;
        if (frame_done !== 1'b0) $display("FAIL midrst_nodone got=%b exp=0", frame_done);
        else pass++;
        tick();
        total++;
        if (regs_flat !== mflat()) $display("FAIL midrst_regs got=%h exp=%h", regs_flat, mflat());
        else pass++;
    endtask

    task automatic test_write_burst();
        cs_low();
        put(8'h03);
        total++;
        if ({wr_strobe, cmd_err} !== 2'b00) $display("FAIL wb_cmd got=%b exp=00", {wr_strobe, cmd_err});
        else pass++;
        put(8'h11);
        m[3] = 8'h11;
        total++;
        if (wr_strobe !== 1'b1 || wr_addr !== 4'd3) $display("FAIL wb_wr0 got=%b/%0d exp=1/3", wr_strobe, wr_addr);
        else pass++;
        put(8'h22);
        m[4] = 8'h22;
        total++;
        if (wr_strobe !== 1'b1 || wr_addr !== 4'd4) $display("FAIL wb_wr1 got=%b/%0d exp=1/4", wr_strobe, wr_addr);
        else pass++;
        tick();
        total++;
        if (wr_strobe !== 1'b0) $display("FAIL wb_strobe_end got=%b exp=0", wr_strobe);
        else pass++;
        total++;
        if (regs_flat !== mflat()) $display("FAIL wb_regs got=%h exp=%h", regs_flat, mflat());
        else pass++;
        cs_n = 1'b1;
        tick();
        total++;
        if (frame_done !== 1'b1 || tx_byte !== 8'h00) $display("FAIL wb_done got=%b/%h exp=1/00", frame_done, tx_byte);
        else pass++;
        tick();
        total++;
        if (frame_done !== 1'b0) $display("FAIL wb_done_once got=%b exp=0", frame_done);
        else pass++;
    endtask

    task automatic test_read_wrap();
        cs_low();
        put(8'h0F);
        put(8'h5A);
        m[15] = 8'h5A;
        total++;
        if (wr_strobe !== 1'b1 || wr_addr !== 4'd15) $display("FAIL ww_15 got=%b/%0d exp=1/15", wr_strobe, wr_addr);
        else pass++;
        put(8'h00);
        total++;
        if (wr_strobe !== 1'b1 || wr_addr !== 4'd0) $display("FAIL ww_0 got=%b/%0d exp=1/0", wr_strobe, wr_addr);
        else pass++;
        put(8'h3C);
        m[1] = 8'h3C;
        total++;
        if (wr_strobe !== 1'b1 || wr_addr !== 4'd1) $display("FAIL ww_1 got=%b/%0d exp=1/1", wr_strobe, wr_addr);
        else pass++;
        cs_high();
        cs_low();
        put(8'h8F);
        total++;
        if (tx_byte !== 8'h5A || wr_strobe !== 1'b0) $display("FAIL rw_15 got=%h/%b exp=5A/0", tx_byte, wr_strobe);
        else pass++;
        put(8'h00);
        total++;
        if (tx_byte !== 8'hA5) $display("FAIL rw_0 got=%h exp=A5", tx_byte);
        else pass++;
        put(8'h00);
        total++;
        if (tx_byte !== 8'h3C) $display("FAIL rw_1 got=%h exp=3C", tx_byte);
        else pass++;
        total++;
        if (regs_flat !== mflat()) $display("FAIL rw_regs got=%h exp=%h", regs_flat, mflat());
        else pass++;
        cs_high();
    endtask

    task automatic test_read_only_id();
        cs_low();
        put(8'h00);
        put(8'hFF);
        total++;
        if (wr_strobe !== 1'b1 || wr_addr !== 4'd0) $display("FAIL id_wr got=%b/%0d exp=1/0", wr_strobe, wr_addr);
        else pass++;
        tick();
        total++;
        if (regs_flat[7:0] !== 8'hA5) $display("FAIL id_reg0 got=%h exp=A5", regs_flat[7:0]);
        else pass++;
        cs_high();
        cs_low();
        put(8'h80);
        total++;
        if (tx_byte !== 8'hA5) $display("FAIL id_rd got=%h exp=A5", tx_byte);
        else pass++;
        cs_high();
    endtask

    task automatic test_invalid();
        cs_low();
        put(8'h20);
        total++;
        if (cmd_err !== 1'b1 || tx_byte !== 8'hEE) $display("FAIL inv_cmd got=%b/%h exp=1/EE", cmd_err, tx_byte);
        else pass++;
        put(8'h55);
        total++;
        if ({cmd_err, wr_strobe} !== 2'b00 || tx_byte !== 8'hEE)
            $display("FAIL inv_d0 got=%b/%h exp=00/EE", {cmd_err, wr_strobe}, tx_byte);
        else pass++;
        put(8'h66);
        total++;
        if (wr_strobe !== 1'b0 || tx_byte !== 8'hEE) $display("FAIL inv_d1 got=%b/%h exp=0/EE", wr_strobe, tx_byte);
        else pass++;
        total++;
        if (regs_flat !== mflat()) $display("FAIL inv_regs got=%h exp=%h", regs_flat, mflat());
        else pass++;
        cs_n = 1'b1;
        tick();
        total++;
        if (frame_done !== 1'b1 || tx_byte !== 8'h00) $display("FAIL inv_done got=%b/%h exp=1/00", frame_done, tx_byte);
        else pass++;
        tick();
    endtask

    task automatic test_abort();
        cs_low();
        put(8'h09);
        put(8'hAB);
        m[9] = 8'hAB;
        total++;
        if (wr_strobe !== 1'b1 || wr_addr !== 4'd9) $display("FAIL ab_wr got=%b/%0d exp=1/9", wr_strobe, wr_addr);
        else pass++;
        rx_byte = 8'hCD;
        rx_valid = 1'b1;
        cs_n = 1'b1;
        tick();
        rx_valid = 1'b0;
        total++;
        if (wr_strobe !== 1'b0 || frame_done !== 1'b1 || tx_byte !== 8'h00)
            $display("FAIL ab_end got=%b/%b/%h exp=0/1/00", wr_strobe, frame_done, tx_byte);
        else pass++;
        total++;
        if (regs_flat !== mflat()) $display("FAIL ab_regs got=%h exp=%h", regs_flat, mflat());
        else pass++;
        put(8'h0A);
        total++;
        if (wr_strobe !== 1'b0 || cmd_err !== 1'b0 || frame_done !== 1'b0)
            $display("FAIL ab_idle_rx got=%b%b%b exp=000", wr_strobe, cmd_err, frame_done);
        else pass++;
        cs_low();
        put(8'h89);
        total++;
        if (tx_byte !== 8'hAB) $display("FAIL ab_rd9 got=%h exp=AB", tx_byte);
        else pass++;
        put(8'h00);
        total++;
        if (tx_byte !== m[10]) $display("FAIL ab_rd10 got=%h exp=%h", tx_byte, m[10]);
        else pass++;
        cs_high();
    endtask

    task automatic test_back_to_back();
        cs_low();
        rx_valid = 1'b1;
        rx_byte = 8'h06;
        tick();
        rx_byte = 8'hC1;
        tick();
        m[6] = 8'hC1;
        total++;
        if (wr_strobe !== 1'b1 || wr_addr !== 4'd6) $display("FAIL b2b_w6 got=%b/%0d exp=1/6", wr_strobe, wr_addr);
        else pass++;
        rx_byte = 8'hC2;
        tick();
        m[7] = 8'hC2;
        total++;
        if (wr_strobe !== 1'b1 || wr_addr !== 4'd7) $display("FAIL b2b_w7 got=%b/%0d exp=1/7", wr_strobe, wr_addr);
        else pass++;
        rx_byte = 8'hC3;
        tick();
        m[8] = 8'hC3;
        rx_valid = 1'b0;
        total++;
        if (wr_strobe !== 1'b1 || wr_addr !== 4'd8) $display("FAIL b2b_w8 got=%b/%0d exp=1/8", wr_strobe, wr_addr);
        else pass++;
        cs_high();
        cs_low();
        rx_valid = 1'b1;
        rx_byte = 8'h86;
        tick();
        total++;
        if (tx_byte !== 8'hC1) $display("FAIL b2b_r6 got=%h exp=C1", tx_byte);
        else pass++;
        rx_byte = 8'h00;
        tick();
        total++;
        if (tx_byte !== 8'hC2) $display("FAIL b2b_r7 got=%h exp=C2", tx_byte);
        else pass++;
        tick();
        rx_valid = 1'b0;
        total++;
        if (tx_byte !== 8'hC3) $display("FAIL b2b_r8 got=%h exp=C3", tx_byte);
        else pass++;
        total++;
        if (regs_flat !== mflat()) $display("FAIL b2b_regs got=%h exp=%h", regs_flat, mflat());
        else pass++;
        cs_high();
    endtask

    initial begin
        test_reset();
        test_write_burst();
        test_read_wrap();
        test_read_only_id();
        test_invalid();
        test_abort();
        test_back_to_back();
        $display("%0d/%0d checks passed", pass, total);
        $finish;
    end

endmodule
